// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared FSM state type and grant identifiers for mem_responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM with one-cycle read, read-before-write
module mem_array #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  // access the array only when enabled; contents are never reset
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem[addr_i] <= wdata_i;
      rdata_o <= mem[addr_i];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: round-robin arbiter serving instruction and data ports from one shared RAM
module mem_responder import mem_resp_pkg::*; #(
  parameter int          ADDR_W   = 10,
  parameter int          DATA_W   = 32,
  parameter int unsigned WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_rsp_valid,
  output logic [DATA_W-1:0] i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_req_wdata,
  output logic              d_rsp_valid,
  output logic [DATA_W-1:0] d_rsp_data,
  output logic              busy
);
  localparam logic [3:0] WC = 4'(WAIT_CYC);
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic last_q, port_q, we_q;
  logic [ADDR_W-1:0] addr_q, ram_addr;
  logic [DATA_W-1:0] wdata_q, ram_wdata, rdata;
  logic idle, both, acc_i, acc_d, acc, from_in, ram_en, ram_we;
  assign idle        = state_q == IDLE && !rst;
  assign both        = i_req_valid && d_req_valid;
  assign i_req_ready = idle && !(both && last_q == GRANT_I);
  assign d_req_ready = idle && !(both && last_q == GRANT_D);
  assign acc_i       = i_req_valid && i_req_ready;
  assign acc_d       = d_req_valid && d_req_ready;
  assign acc         = acc_i || acc_d;
  assign busy        = state_q != IDLE;
  // with zero wait states the RAM is driven straight from the accepted request
  assign from_in     = state_q == IDLE;
  assign ram_en      = state_d == RESP;
  assign ram_addr    = from_in ? (acc_i ? i_req_addr : d_req_addr) : addr_q;
  assign ram_we      = from_in ? (acc_d && d_req_we) : we_q;
  assign ram_wdata   = from_in ? d_req_wdata : wdata_q;
  // next state and wait-counter sequencing
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && acc) begin
      state_d = (WAIT_CYC == 0) ? RESP : WAIT;
      cnt_d   = (WAIT_CYC == 0) ? 4'd0 : WC - 4'd1;
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 4'd0) ? RESP : WAIT;
      cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  // FSM state, wait counter and request capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= GRANT_D;
      port_q  <= GRANT_D;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (acc) begin
        last_q  <= acc_i ? GRANT_I : GRANT_D;
        port_q  <= acc_i ? GRANT_I : GRANT_D;
        we_q    <= acc_d && d_req_we;
        addr_q  <= ram_addr;
        wdata_q <= d_req_wdata;
      end
    end
  end
  // register the winner's response out of RESP; data holds between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      i_rsp_data  <= '0;
      d_rsp_data  <= '0;
    end else begin
      i_rsp_valid <= state_q == RESP && port_q == GRANT_I;
      d_rsp_valid <= state_q == RESP && port_q == GRANT_D;
      if (state_q == RESP && port_q == GRANT_I) i_rsp_data <= rdata;
      if (state_q == RESP && port_q == GRANT_D) d_rsp_data <= we_q ? wdata_q : rdata;
    end
  end
  mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_arr (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (rdata)
  );
endmodule
